// File: rtl/mbist_pkg.sv
// Shared types and defaults for the March LR BIST controller and its verify sweep.
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int AW_DEF      = 8;
    localparam int DW_DEF      = 4;
    localparam int RD_LAT_DEF  = 1;
    localparam int TIMEOUT_DEF = 16000;

    // Background the March LR engine leaves in the array when it finishes.
    localparam logic [DW_DEF-1:0] EXPECT_DEF = '0;

endpackage

// File: rtl/mbist_verify_sweep.sv
// Read-back sweep: walks every address, aligns returned data through an RD_LAT-deep
// valid/address pipe and records the mismatch count and first failing address.
module mbist_verify_sweep
    import mbist_pkg::*;
#(
    parameter int             AW     = AW_DEF,
    parameter int             DW     = DW_DEF,
    parameter int             RD_LAT = RD_LAT_DEF,
    parameter logic [DW-1:0]  EXPECT = DW'(EXPECT_DEF)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          active_i,
    input  logic          clear_i,
    input  logic [DW-1:0] rdata_i,
    output logic [AW-1:0] addr_o,
    output logic          sweep_done_o,
    output logic [AW:0]   fail_cnt_o,
    output logic [AW-1:0] fail_addr_o,
    output logic          fail_any_o
);

    localparam int            CW   = AW + 2;
    localparam logic [CW-1:0] NUM  = CW'(2**AW);
    localparam logic [CW-1:0] LAST = CW'(2**AW + RD_LAT - 1);

    logic [CW-1:0]              cyc_q, cyc_d;
    logic [RD_LAT-1:0]          vld_q, vld_d;
    logic [RD_LAT-1:0][AW-1:0]  paddr_q, paddr_d;
    logic [AW:0]                cnt_q, cnt_d;
    logic [AW-1:0]              faddr_q, faddr_d;
    logic                       issue;
    logic                       mism;

    assign issue        = active_i && (cyc_q < NUM);
    assign sweep_done_o = active_i && (cyc_q == LAST);
    assign addr_o       = cyc_q[AW-1:0];
    assign mism         = vld_q[RD_LAT-1] && (rdata_i != EXPECT);

    always_comb begin
        cyc_d      = (active_i && !sweep_done_o) ? cyc_q + CW'(1) : '0;
        vld_d      = '0;
        paddr_d    = '0;
        vld_d[0]   = issue;
        paddr_d[0] = cyc_q[AW-1:0];
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]   = vld_q[i-1];
            paddr_d[i] = paddr_q[i-1];
        end
    end

    // Only the first mismatch latches its address; later ones just count.
    always_comb begin
        cnt_d   = cnt_q;
        faddr_d = faddr_q;
        if (clear_i) begin
            cnt_d   = '0;
            faddr_d = '0;
        end else if (mism) begin
            cnt_d = cnt_q + (AW+1)'(1);
            if (cnt_q == '0) begin
                faddr_d = paddr_q[RD_LAT-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= '0;
            vld_q   <= '0;
            paddr_q <= '0;
            cnt_q   <= '0;
            faddr_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            vld_q   <= vld_d;
            paddr_q <= paddr_d;
            cnt_q   <= cnt_d;
            faddr_q <= faddr_d;
        end
    end

    assign fail_cnt_o  = cnt_q;
    assign fail_addr_o = faddr_q;
    assign fail_any_o  = (cnt_q != '0) || mism;

endmodule

// File: rtl/mbist_ctrl.sv
// BIST controller: arbitrates the SRAM port between the functional requester and the
// March LR engine, bounds the engine run with a timeout and reports the sweep result.
module mbist_ctrl
    import mbist_pkg::*;
#(
    parameter int            AW      = AW_DEF,
    parameter int            DW      = DW_DEF,
    parameter int            RD_LAT  = RD_LAT_DEF,
    parameter int            TIMEOUT = TIMEOUT_DEF,
    parameter logic [DW-1:0] EXPECT  = DW'(EXPECT_DEF)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bist_start,
    output logic          bist_busy,
    output logic          bist_done,
    output logic          bist_pass,
    output logic          bist_timeout,
    output logic [AW-1:0] fail_addr,
    output logic [AW:0]   fail_cnt,
    input  logic          fn_req,
    input  logic          fn_we,
    input  logic [AW-1:0] fn_addr,
    input  logic [DW-1:0] fn_wdata,
    output logic          fn_gnt,
    output logic [DW-1:0] fn_rdata,
    output logic          eng_en,
    input  logic [AW-1:0] eng_addr,
    input  logic [DW-1:0] eng_wdata,
    input  logic          eng_we,
    input  logic          eng_done,
    output logic [DW-1:0] eng_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e         state_q, state_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           pass_q, pass_d;
    logic           to_q, to_d;
    logic           start_acc;
    logic           timeout_hit;
    logic [AW-1:0]  sweep_addr;
    logic           sweep_done;
    logic           fail_any;

    assign start_acc   = (state_q == ST_IDLE) && bist_start;
    assign timeout_hit = (state_q == ST_RUN) && !eng_done && (tcnt_q == TW'(TIMEOUT - 1));

    mbist_verify_sweep #(
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT),
        .EXPECT (EXPECT)
    ) u_sweep (
        .clk          (clk),
        .rst_n        (rst_n),
        .active_i     (state_q == ST_VERIFY),
        .clear_i      (start_acc),
        .rdata_i      (mem_rdata),
        .addr_o       (sweep_addr),
        .sweep_done_o (sweep_done),
        .fail_cnt_o   (fail_cnt),
        .fail_addr_o  (fail_addr),
        .fail_any_o   (fail_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            pass_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            pass_q  <= pass_d;
            to_q    <= to_d;
        end
    end

    // eng_done beats a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (bist_start) state_d = ST_RUN;
            ST_RUN:    if (eng_done) state_d = ST_VERIFY;
                       else if (timeout_hit) state_d = ST_DONE;
            ST_VERIFY: if (sweep_done) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Results are settled on the edge into DONE so they are valid with bist_done.
    always_comb begin
        tcnt_d = (state_q == ST_RUN) ? tcnt_q + TW'(1) : '0;
        pass_d = pass_q;
        to_d   = to_q;
        if (start_acc) begin
            pass_d = 1'b0;
            to_d   = 1'b0;
        end else if (timeout_hit) begin
            to_d = 1'b1;
        end else if ((state_q == ST_VERIFY) && sweep_done) begin
            pass_d = !fail_any && !to_q;
        end
    end

    always_comb begin
        fn_gnt    = 1'b0;
        eng_en    = 1'b0;
        mem_addr  = fn_addr;
        mem_wdata = fn_wdata;
        mem_we    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                fn_gnt = fn_req;
                mem_we = fn_req && fn_we;
            end
            ST_RUN: begin
                eng_en    = 1'b1;
                mem_addr  = eng_addr;
                mem_wdata = eng_wdata;
                mem_we    = eng_we;
            end
            ST_VERIFY: begin
                mem_addr  = sweep_addr;
                mem_wdata = EXPECT;
            end
            default: ;
        endcase
    end

    assign bist_busy    = (state_q != ST_IDLE);
    assign bist_done    = (state_q == ST_DONE);
    assign bist_pass    = pass_q;
    assign bist_timeout = to_q;
    assign fn_rdata     = mem_rdata;
    assign eng_rdata    = mem_rdata;

endmodule

// File: tb/tb_mbist_ctrl.sv
// Directed bench for mbist_ctrl: two instances (RD_LAT=1 and RD_LAT=3, TIMEOUT=100)
// with behavioural SRAM and engine models, table-driven runs plus corner sequences.
module tb_mbist_ctrl;

    localparam int DLY = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, mem_clr;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit         never_done, stuck_on, ones_on;
    logic [3:0] eng_wd;
    int         nchk = 0, nerr = 0;

    logic       start_a, busy_a, done_a, pass_a, to_a, fn_gnt_a, en_a, ewe_a, edone_a, mwe_a;
    logic [7:0] faddr_a, eaddr_a, maddr_a;
    logic [8:0] fcnt_a;
    logic [3:0] fn_rdata_a, ewd_a, erd_a, mwd_a, mrd_a;
    logic       fn_req, fn_we;
    logic [7:0] fn_addr;
    logic [3:0] fn_wdata;

    logic       start_b, busy_b, done_b, pass_b, to_b, fn_gnt_b, en_b, ewe_b, edone_b, mwe_b;
    logic [7:0] faddr_b, eaddr_b, maddr_b;
    logic [8:0] fcnt_b;
    logic [3:0] fn_rdata_b, ewd_b, erd_b, mwd_b, mrd_b;

    mbist_ctrl #(.AW(8), .DW(4), .RD_LAT(1), .TIMEOUT(100), .EXPECT(4'h0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bist_start(start_a), .bist_busy(busy_a),
        .bist_done(done_a), .bist_pass(pass_a), .bist_timeout(to_a),
        .fail_addr(faddr_a), .fail_cnt(fcnt_a),
        .fn_req(fn_req), .fn_we(fn_we), .fn_addr(fn_addr), .fn_wdata(fn_wdata),
        .fn_gnt(fn_gnt_a), .fn_rdata(fn_rdata_a),
        .eng_en(en_a), .eng_addr(eaddr_a), .eng_wdata(ewd_a), .eng_we(ewe_a),
        .eng_done(edone_a), .eng_rdata(erd_a),
        .mem_addr(maddr_a), .mem_wdata(mwd_a), .mem_we(mwe_a), .mem_rdata(mrd_a)
    );

    mbist_ctrl #(.AW(8), .DW(4), .RD_LAT(3), .TIMEOUT(100), .EXPECT(4'h0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bist_start(start_b), .bist_busy(busy_b),
        .bist_done(done_b), .bist_pass(pass_b), .bist_timeout(to_b),
        .fail_addr(faddr_b), .fail_cnt(fcnt_b),
        .fn_req(1'b0), .fn_we(1'b0), .fn_addr(8'h00), .fn_wdata(4'h0),
        .fn_gnt(fn_gnt_b), .fn_rdata(fn_rdata_b),
        .eng_en(en_b), .eng_addr(eaddr_b), .eng_wdata(ewd_b), .eng_we(ewe_b),
        .eng_done(edone_b), .eng_rdata(erd_b),
        .mem_addr(maddr_b), .mem_wdata(mwd_b), .mem_we(mwe_b), .mem_rdata(mrd_b)
    );

    // Engine models: write eng_wd to successive addresses, pulse done after DLY cycles.
    int ecnt_a = 0, ecnt_b = 0;
    always @(posedge clk) ecnt_a <= en_a ? ecnt_a + 1 : 0;
    always @(posedge clk) ecnt_b <= en_b ? ecnt_b + 1 : 0;
    assign edone_a = en_a && !never_done && (ecnt_a == DLY);
    assign edone_b = en_b && !never_done && (ecnt_b == DLY);
    assign eaddr_a = 8'(ecnt_a);
    assign eaddr_b = 8'(ecnt_b);
    assign ewe_a   = en_a;
    assign ewe_b   = en_b;
    assign ewd_a   = eng_wd;
    assign ewd_b   = eng_wd;

    // SRAM models: a has latency 1 with optional stuck-at-1 on bit 0, b has latency 3.
    logic [3:0] mem_a [256];
    logic [3:0] mem_b [256];
    logic [3:0] rd_a, rd_b0, rd_b1, rd_b2;
    always @(posedge clk) begin
        if (mem_clr) for (int i = 0; i < 256; i++) mem_a[i] <= '0;
        else if (mwe_a) mem_a[maddr_a] <= mwd_a;
        rd_a <= mem_a[maddr_a] | {3'b000, stuck_on && (maddr_a == 8'h3C || maddr_a == 8'hA0)};
    end
    always @(posedge clk) begin
        if (mem_clr) for (int i = 0; i < 256; i++) mem_b[i] <= '0;
        else if (mwe_b) mem_b[maddr_b] <= mwd_b;
        rd_b0 <= ones_on ? 4'hF : mem_b[maddr_b];
        rd_b1 <= rd_b0;
        rd_b2 <= rd_b1;
    end
    assign mrd_a = rd_a;
    assign mrd_b = rd_b2;

    logic       sel;
    logic       s_done, s_busy, s_en, s_pass, s_to;
    logic [8:0] s_cnt;
    logic [7:0] s_faddr;
    assign s_done  = sel ? done_b  : done_a;
    assign s_busy  = sel ? busy_b  : busy_a;
    assign s_en    = sel ? en_b    : en_a;
    assign s_pass  = sel ? pass_b  : pass_a;
    assign s_to    = sel ? to_b    : to_a;
    assign s_cnt   = sel ? fcnt_b  : fcnt_a;
    assign s_faddr = sel ? faddr_b : faddr_a;

    typedef struct {
        string      name;
        bit         use_b;
        bit         never;
        logic [3:0] wd;
        bit         ones;
        bit         stuck;
        bit         exp_pass;
        bit         exp_to;
        int         exp_cnt;
        int         exp_faddr;
        int         exp_vcyc;
        int         exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int c0, vcnt, lat;
        bit seen;
        sel = v.use_b; never_done = v.never; eng_wd = v.wd; ones_on = v.ones; stuck_on = v.stuck;
        @(negedge clk);
        if (v.use_b) start_b = 1'b1; else start_a = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        chk({v.name, "_eng_en"}, 32'(s_en), 1);
        vcnt = 0; seen = 0;
        for (int k = 0; k < 2000; k++) begin
            if (s_done) begin seen = 1; break; end
            if (s_busy && !s_en) vcnt++;
            @(posedge clk); #1;
        end
        lat = cyc - c0;
        chk({v.name, "_done_seen"}, 32'(seen), 1);
        chk({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({v.name, "_verify_cycles"}, 32'(vcnt), 32'(v.exp_vcyc));
        chk({v.name, "_pass"}, 32'(s_pass), 32'(v.exp_pass));
        chk({v.name, "_timeout"}, 32'(s_to), 32'(v.exp_to));
        chk({v.name, "_fail_cnt"}, 32'(s_cnt), 32'(v.exp_cnt));
        chk({v.name, "_fail_addr"}, 32'(s_faddr), 32'(v.exp_faddr));
        @(posedge clk); #1;
        chk({v.name, "_done_pulse"}, 32'(s_done), 0);
        chk({v.name, "_idle_busy"}, 32'(s_busy), 0);
        chk({v.name, "_pass_held"}, 32'(s_pass), 32'(v.exp_pass));
        stuck_on = 0; ones_on = 0; never_done = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bad, waited;
        bit  seen;
        rst_n = 1'b0; mem_clr = 1'b1;
        start_a = 0; start_b = 0; fn_req = 0; fn_we = 0; fn_addr = '0; fn_wdata = '0;
        never_done = 0; stuck_on = 0; ones_on = 0; eng_wd = 4'h0; sel = 0;

        vecs[0] = '{"clean_lat1",  0, 0, 4'h0, 0, 0, 1, 0,   0,    0, 257, 279};
        vecs[1] = '{"stuck_lat1",  0, 0, 4'h0, 0, 1, 0, 0,   2, 8'h3C, 257, 279};
        vecs[2] = '{"timeout",     0, 1, 4'h0, 0, 0, 0, 1,   0,    0,   0, 101};
        vecs[3] = '{"ones_lat3",   1, 0, 4'hF, 1, 0, 0, 0, 256,    0, 259, 281};
        vecs[4] = '{"clean_again", 0, 0, 4'h0, 0, 0, 1, 0,   0,    0, 257, 279};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_pass", 32'(pass_a), 0);
        chk("rst_timeout", 32'(to_a), 0);
        chk("rst_eng_en", 32'(en_a), 0);
        chk("rst_fn_gnt", 32'(fn_gnt_a), 0);
        chk("rst_mem_we", 32'(mwe_a), 0);
        chk("rst_fail_addr", 32'(faddr_a), 0);
        chk("rst_fail_cnt", 32'(fcnt_a), 0);
        rst_n = 1'b1; mem_clr = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Functional request alongside start: granted that cycle, stalled, then restored.
        sel = 0;
        @(negedge clk);
        fn_req = 1; fn_we = 1; fn_addr = 8'h10; fn_wdata = 4'h5; start_a = 1;
        #1;
        chk("fn_gnt_with_start", 32'(fn_gnt_a), 1);
        @(posedge clk); #1;
        start_a = 0;
        bad = 0; seen = 0;
        for (int k = 0; k < 2000; k++) begin
            if (fn_gnt_a) bad++;
            if (done_a) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        chk("fn_gnt_stalled", 32'(bad), 0);
        chk("fn_done_seen", 32'(seen), 1);
        chk("fn_run_pass", 32'(pass_a), 1);
        @(posedge clk); #1;
        chk("fn_gnt_after_done", 32'(fn_gnt_a), 1);
        @(posedge clk); #1;
        fn_we = 0;
        @(posedge clk); #1;
        chk("fn_readback", 32'(fn_rdata_a), 32'h5);
        fn_req = 0;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of the verify sweep.
        stuck_on = 1;
        @(negedge clk);
        start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
        seen = 0; waited = 0;
        for (int k = 0; k < 2000; k++) begin
            if (fcnt_a != 0) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        chk("rst_mid_reached_verify", 32'(seen && busy_a && !en_a), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_eng_en", 32'(en_a), 0);
        chk("rst_mid_busy", 32'(busy_a), 0);
        chk("rst_mid_fail_cnt", 32'(fcnt_a), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        stuck_on = 0;
        @(posedge clk); #1;
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/mbist_ctrl.md
# mbist_ctrl

Controller that sequences the March LR BIST engine against the 256x4 SRAM and shares the SRAM port between the functional requester and BIST. On a start pulse it hands the memory port to the engine and enables it. It then waits for the engine's done pulse, or for a timeout. Finally it runs its own read-back sweep, expecting the all-zero background the engine leaves behind, and reports pass/fail, the first failing address and the fail count.

## Interface
- AW, 8, address width (array depth 2**AW)
- DW, 4, data width
- RD_LAT, 1, SRAM read latency in cycles (1..3)
- TIMEOUT, 16000, max cycles allowed in RUN
- EXPECT, {DW{1'b0}}, background expected in verify sweep

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- bist_start  in  1  one-cycle start request
- bist_busy  out  1  high in RUN, VERIFY and DONE
- bist_done  out  1  one-cycle pulse at end of test
- bist_pass  out  1  result, held until next accepted start
- bist_timeout  out  1  engine did not finish, held until next start
- fail_addr  out  AW  first mismatching address
- fail_cnt  out  AW+1  number of mismatching addresses (0..256)
- fn_req / fn_we  in  1  functional access request / write
- fn_addr  in  AW; fn_wdata  in  DW
- fn_gnt  out  1  functional access granted this cycle
- fn_rdata  out  DW  = mem_rdata
- eng_en  out  1  drives engine en_in
- eng_addr  in  AW; eng_wdata  in  DW; eng_we  in  1  engine memory outputs
- eng_done  in  1  engine rst_done
- eng_rdata  out  DW  = mem_rdata
- mem_addr  out  AW; mem_wdata  out  DW; mem_we  out  1  SRAM port
- mem_rdata  in  DW

## Operation
- State register: IDLE, RUN, VERIFY, DONE.
- **IDLE:**
  - SRAM owned by the functional port: fn_gnt=fn_req; mem_addr=fn_addr; mem_wdata=fn_wdata; mem_we=fn_req&fn_we.
  - bist_start → RUN next cycle.
  - A functional request in the same cycle as bist_start is still granted.
- **RUN:**
  - eng_en=1; mem_* = eng_*; fn_gnt=0, so functional requests stall.
  - Cycle counter starts at 0 on entry.
  - eng_done=1 → VERIFY.
  - If the counter reaches TIMEOUT-1 without eng_done → DONE with bist_timeout=1.
  - eng_done and timeout in the same cycle: eng_done wins.
- **VERIFY:**
  - eng_en=0; mem_we=0; mem_addr steps 0..2**AW-1, one per cycle.
  - A valid/address shift pipe of depth RD_LAT aligns each returned mem_rdata with its address.
  - On mismatch against EXPECT: fail_cnt++; on the first mismatch, capture fail_addr.
  - After the last address is issued, drain RD_LAT cycles → DONE.
- **DONE:** one cycle; bist_done=1; bist_pass = (fail_cnt==0) & ~bist_timeout → IDLE.
- bist_start outside IDLE is ignored.
- Accepted start clears fail_cnt, fail_addr, bist_pass and bist_timeout.
- fail_cnt cannot overflow: it is AW+1 bits wide.

## Timing
- Reset values: bist_busy, bist_done, bist_pass, bist_timeout, eng_en, fn_gnt, mem_we = 0; fail_addr=0; fail_cnt=0; state IDLE.
- rst_n low mid-test: immediate return to IDLE; eng_en drops asynchronously; results cleared.
- Start to eng_en high: 1 cycle.
- eng_done to first verify read: 1 cycle.
- VERIFY length: 2**AW + RD_LAT cycles.
- eng_done to bist_done: 2**AW + RD_LAT + 1 cycles.
- The mem_* mux is combinational on the registered state, so there are no mid-cycle owner changes.
- Result outputs are registered and stable from the bist_done cycle onward.

## Structure
- Shared package mbist_pkg holds:
  - state enum: IDLE/RUN/VERIFY/DONE
  - AW/DW defaults
  - EXPECT background constant
  - TIMEOUT default
- Sub-module mbist_verify_sweep:
  - address counter
  - RD_LAT-deep valid/address pipe
  - comparator
  - fail_cnt/fail_addr capture
  - sweep_done output
- The top level holds the FSM, the timeout counter and the port mux.

## Test plan
- Fault-free SRAM model, RD_LAT=1: pulse bist_start → eng_en high next cycle; bist_done pulses 257+1 cycles after eng_done; bist_pass=1, fail_cnt=0, bist_timeout=0.
- Stuck-at-1 bit 0 at address 8'h3C and 8'hA0 → bist_pass=0, fail_addr=8'h3C, fail_cnt=2.
- Engine model that never asserts eng_done, TIMEOUT=100 → bist_done at cycle 101 after start; bist_timeout=1; bist_pass=0; no verify reads issued.
- fn_req=1 in the same cycle as bist_start → fn_gnt=1 that cycle, then 0 through the whole test; fn_gnt returns the cycle after bist_done; a functional write of 4'h5 to 8'h10 reads back 4'h5.
- rst_n low mid-VERIFY → eng_en, bist_busy, fail_cnt all 0 immediately; a subsequent start yields a normal pass.
- RD_LAT=3, all-ones array left by a faulty engine → fail_cnt=256, fail_addr=0, and the verify sweep lasts 259 cycles.
